// File: rtl/aes_inv_cipher_iter_pkg.sv
// Shared AES constants, inverse S-box, GF(2^8) helpers and byte-layout helper.
// Latency: pure functions and constants, no state.
// Backpressure: not applicable.
package aes_pkg;

    localparam int NB     = 4;
    localparam int NR128  = 10;
    localparam int NR192  = 12;
    localparam int NR256  = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } inv_state_t;

    // Inverse S-box, entry 0x00 in the top byte.
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX_TBL[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_09(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0b(input logic [7:0] b);
        logic [7:0] x2;
        x2 = xtime(b);
        return xtime(xtime(x2)) ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0d(input logic [7:0] b);
        logic [7:0] x4;
        x4 = xtime(xtime(b));
        return xtime(x4) ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0e(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        x2 = xtime(b);
        x4 = xtime(x2);
        return xtime(x4) ^ x4 ^ x2;
    endfunction

    // MSB position of state byte (row, col); byte n = row + 4*col sits at [127-8n -: 8].
    function automatic int byte_msb(input int row, input int col);
        return 127 - 8 * (row + NB * col);
    endfunction

endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and round-key port bundle between the inverse cipher and its neighbours.
// Latency: wires only.
// Backpressure: valid/ready on both the ciphertext and plaintext sides.
interface aes_inv_cipher_iter_if #(
    parameter int RKW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic [RKW-1:0] rk_idx;
    logic [127:0]   rk_data;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;

    modport slave (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_inv_cipher_iter_round.sv
// One AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
// Latency: combinational.
// Backpressure: none, purely combinational.

// Row rotation shared with the encrypt side; inv selects the right-rotating direction.
module aes_shift_rows
    import aes_pkg::*;
(
    input  logic         inv,
    input  logic [127:0] st_in,
    output logic [127:0] st_out
);
    for (genvar r = 0; r < NB; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int DST = byte_msb(r, c);
            localparam int FWD = byte_msb(r, (c + r) % NB);
            localparam int BWD = byte_msb(r, (c + NB - r) % NB);
            assign st_out[DST -: 8] = inv ? st_in[BWD -: 8] : st_in[FWD -: 8];
        end
    end
endmodule

module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] st_in,
    input  logic [127:0] rk,
    input  logic         last,
    output logic [127:0] st_out
);
    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;
    logic [127:0] mix;

    aes_shift_rows u_shift_rows (
        .inv    (1'b1),
        .st_in  (st_in),
        .st_out (sr)
    );

    for (genvar i = 0; i < 16; i++) begin : g_sub
        assign sb[127 - 8*i -: 8] = inv_sbox(sr[127 - 8*i -: 8]);
    end

    assign ark = sb ^ rk;

    for (genvar c = 0; c < NB; c++) begin : g_mix
        localparam int M = byte_msb(0, c);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        assign a0 = ark[M      -: 8];
        assign a1 = ark[M - 8  -: 8];
        assign a2 = ark[M - 16 -: 8];
        assign a3 = ark[M - 24 -: 8];
        assign mix[M      -: 8] = gmul_0e(a0) ^ gmul_0b(a1) ^ gmul_0d(a2) ^ gmul_09(a3);
        assign mix[M - 8  -: 8] = gmul_09(a0) ^ gmul_0e(a1) ^ gmul_0b(a2) ^ gmul_0d(a3);
        assign mix[M - 16 -: 8] = gmul_0d(a0) ^ gmul_09(a1) ^ gmul_0e(a2) ^ gmul_0b(a3);
        assign mix[M - 24 -: 8] = gmul_0b(a0) ^ gmul_0d(a1) ^ gmul_09(a2) ^ gmul_0e(a3);
    end

    // The final round of the inverse cipher has no InvMixColumns.
    assign st_out = last ? ark : mix;
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one round per clock, keys fetched by index.
// Latency: out_valid rises NR edges after the accept edge; one block per NR+2 cycles at best.
// Backpressure: plaintext held in DONE until out_ready; in_ready only in IDLE.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int NR  = NR128,
    parameter int RKW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    aes_inv_cipher_iter_if.slave bus
);
    localparam logic [RKW-1:0] IDX_NR    = RKW'(NR);
    localparam logic [RKW-1:0] IDX_FIRST = RKW'(NR - 1);

    inv_state_t     state_q;
    logic [RKW-1:0] rnd_q;
    logic [RKW-1:0] rk_idx_q;
    logic [127:0]   st_q;
    logic [127:0]   out_data_q;
    logic           out_valid_q;
    logic           in_ready_q;
    logic           busy_q;
    logic [127:0]   round_d;

    aes_inv_round u_round (
        .st_in  (st_q),
        .rk     (bus.rk_data),
        .last   (rnd_q == '0),
        .st_out (round_d)
    );

    // Control FSM with round counter, working state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            rk_idx_q    <= IDX_NR;
            st_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        // Initial AddRoundKey with the last round key.
                        st_q       <= bus.in_data ^ bus.rk_data;
                        rnd_q      <= IDX_FIRST;
                        rk_idx_q   <= IDX_FIRST;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    st_q <= round_d;
                    if (rnd_q != '0) begin
                        rnd_q    <= rnd_q - 1'b1;
                        rk_idx_q <= rnd_q - 1'b1;
                    end else begin
                        out_data_q  <= round_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        rk_idx_q    <= IDX_NR;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.rk_idx    = rk_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Self-checking bench: AES-128 and AES-256 instances against a forward-cipher model.
// Latency: checks NR edges from accept to out_valid.
// Backpressure: exercises held out_ready, back-to-back blocks and mid-operation reset.
module tb_aes_inv_cipher_iter;

    logic clk;
    logic rst_n;

    aes_inv_cipher_iter_if #(.RKW(4)) if10 ();
    aes_inv_cipher_iter_if #(.RKW(4)) if14 ();

    aes_inv_cipher_iter #(.NR(10), .RKW(4)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(if10));
    aes_inv_cipher_iter #(.NR(14), .RKW(4)) u_dut14 (.clk(clk), .rst_n(rst_n), .bus(if14));

    logic [7:0]   sb [256];
    logic [127:0] rk10 [16];
    logic [127:0] rk14 [16];

    assign if10.rk_data = rk10[if10.rk_idx];
    assign if14.rk_data = rk14[if14.rk_idx];

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nk == 4) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    // Forward cipher; the DUT must invert it.
    function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k;
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        for (int n = 0; n < 16; n++) s[n] = pt[127 - 8*n -: 8];
        for (int r = 0; r <= nr; r++) begin
            k = (nr == 14) ? rk14[r] : rk10[r];
            if (r > 0) begin
                for (int n = 0; n < 16; n++) t[n] = sb[s[n]];
                for (int row = 0; row < 4; row++)
                    for (int col = 0; col < 4; col++)
                        s[row + 4*col] = t[row + 4*((col + row) % 4)];
                if (r < nr) begin
                    for (int col = 0; col < 4; col++) begin
                        a0 = s[4*col]; a1 = s[4*col+1]; a2 = s[4*col+2]; a3 = s[4*col+3];
                        s[4*col]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                        s[4*col+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                        s[4*col+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                        s[4*col+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                    end
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ k[127 - 8*n -: 8];
        end
        for (int n = 0; n < 16; n++) res[127 - 8*n -: 8] = s[n];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block through the AES-128 instance; starts and ends at a negedge in IDLE.
    task automatic run10(input logic [127:0] ct, input logic [127:0] pt,
                         input int hold, input bit junk, input string tag);
        int lat;
        bit seq_ok;
        bit hold_ok;
        chk({tag, "_idle_rk"},  128'(if10.rk_idx),   128'(10));
        chk({tag, "_idle_rdy"}, 128'(if10.in_ready), 128'(1));
        if10.in_valid  = 1'b1;
        if10.in_data   = ct;
        if10.out_ready = (hold == 0);
        @(negedge clk);
        if10.in_valid = junk;
        lat = 0;
        seq_ok = 1'b1;
        while (!if10.out_valid && lat < 40) begin
            seq_ok = seq_ok && (if10.rk_idx == 4'(9 - lat)) && !if10.in_ready && if10.busy;
            if (junk) if10.in_data = rnd128();
            @(negedge clk);
            lat++;
        end
        if10.in_valid = 1'b0;
        chk({tag, "_latency"}, 128'(lat),          128'(10));
        chk({tag, "_rk_seq"},  128'(seq_ok),       128'(1));
        chk({tag, "_pt"},      if10.out_data,      pt);
        chk({tag, "_done_rk"}, 128'(if10.rk_idx),  128'(0));
        hold_ok = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            hold_ok = hold_ok && if10.out_valid && (if10.out_data === pt) &&
                      !if10.in_ready && (if10.rk_idx == 4'd0) && if10.busy;
        end
        if (hold > 0) chk({tag, "_hold"}, 128'(hold_ok), 128'(1));
        if10.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_post_vld"}, 128'(if10.out_valid), 128'(0));
        chk({tag, "_post_rdy"}, 128'(if10.in_ready),  128'(1));
        chk({tag, "_post_rk"},  128'(if10.rk_idx),    128'(10));
        chk({tag, "_post_busy"}, 128'(if10.busy),     128'(0));
        if10.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        bit seq_ok;
        logic [127:0] ct_zero;
        logic [127:0] pt_r;
        logic [127:0] ct_r;

        rst_n = 1'b0;
        if10.in_valid = 1'b0; if10.in_data = '0; if10.out_ready = 1'b0;
        if14.in_valid = 1'b0; if14.in_data = '0; if14.out_ready = 1'b0;
        build_sbox();
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        ct_zero = enc(128'h0, 10);

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  128'(if10.in_ready),  128'(1));
        chk("rst_out_valid", 128'(if10.out_valid), 128'(0));
        chk("rst_busy",      128'(if10.busy),      128'(0));
        chk("rst_out_data",  if10.out_data,        128'h0);
        chk("rst_rk_idx",    128'(if10.rk_idx),    128'(10));
        chk("rst_rk_idx14",  128'(if14.rk_idx),    128'(14));
        rst_n = 1'b1;
        @(negedge clk);

        // Known vector, then the same block under 20 cycles of backpressure.
        run10(CT_1, PT_C, 0, 1'b0, "c1");
        run10(CT_1, PT_C, 20, 1'b0, "bp");
        // Input traffic during ROUND must be ignored.
        run10(CT_1, PT_C, 2, 1'b1, "junk");

        // Back-to-back blocks with in_valid held high.
        if10.in_valid = 1'b1; if10.in_data = CT_1; if10.out_ready = 1'b1;
        @(negedge clk);
        lat = 0;
        while (!if10.out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("b2b_lat1", 128'(lat), 128'(10));
        chk("b2b_pt1",  if10.out_data, PT_C);
        if10.in_data = ct_zero;
        @(negedge clk);
        chk("b2b_rdy_after_hs", 128'(if10.in_ready), 128'(1));
        @(negedge clk);
        chk("b2b_busy2", 128'(if10.busy),   128'(1));
        chk("b2b_rk2",   128'(if10.rk_idx), 128'(9));
        if10.in_valid = 1'b0;
        lat = 0;
        while (!if10.out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("b2b_lat2", 128'(lat), 128'(10));
        chk("b2b_pt2",  if10.out_data, 128'h0);
        @(negedge clk);
        chk("b2b_idle_rk", 128'(if10.rk_idx), 128'(10));
        if10.out_ready = 1'b0;

        // Reset in the middle of the rounds.
        if10.in_valid = 1'b1; if10.in_data = CT_1;
        @(negedge clk);
        if10.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", 128'(if10.busy), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 128'(if10.out_valid), 128'(0));
        chk("mid_rst_rdy", 128'(if10.in_ready),  128'(1));
        chk("mid_rst_rk",  128'(if10.rk_idx),    128'(10));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run10(CT_1, PT_C, 0, 1'b0, "post_rst");

        // Reset while plaintext is waiting: out_valid drops without a clock edge.
        if10.in_valid = 1'b1; if10.in_data = CT_1;
        @(negedge clk);
        if10.in_valid = 1'b0;
        lat = 0;
        while (!if10.out_valid && lat < 40) begin @(negedge clk); lat++; end
        chk("done_vld", 128'(if10.out_valid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("done_rst_vld",  128'(if10.out_valid), 128'(0));
        chk("done_rst_data", if10.out_data,        128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random plaintexts through the forward model.
        for (int i = 0; i < 4; i++) begin
            pt_r = rnd128();
            ct_r = enc(pt_r, 10);
            run10(ct_r, pt_r, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
        end

        // AES-256 instance: known vector then one random block.
        for (int v = 0; v < 2; v++) begin
            pt_r = (v == 0) ? PT_C : rnd128();
            ct_r = (v == 0) ? CT_3 : enc(pt_r, 14);
            chk("nr14_idle_rk", 128'(if14.rk_idx), 128'(14));
            if14.in_valid = 1'b1; if14.in_data = ct_r; if14.out_ready = 1'b1;
            @(negedge clk);
            if14.in_valid = 1'b0;
            lat = 0;
            seq_ok = 1'b1;
            while (!if14.out_valid && lat < 60) begin
                seq_ok = seq_ok && (if14.rk_idx == 4'(13 - lat));
                @(negedge clk);
                lat++;
            end
            chk("nr14_latency", 128'(lat),    128'(14));
            chk("nr14_rk_seq",  128'(seq_ok), 128'(1));
            chk("nr14_pt",      if14.out_data, pt_r);
            @(negedge clk);
            chk("nr14_post_rk",  128'(if14.rk_idx),    128'(14));
            chk("nr14_post_vld", 128'(if14.out_valid), 128'(0));
            if14.out_ready = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
